// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between an instruction requester and a
// data requester. Data normally has priority; a request is granted for as many
// cycles as the RAM needs, then answered with a single-cycle response.
// Optional feature macro: ARB_FAIRNESS_EN. When defined, the instruction side
// is guaranteed a grant after FAIR_LIMIT consecutive data grants taken while it
// was waiting. When undefined, strict data priority applies and no counter exists.
module memory_arbiter #(
  parameter int          FAIR_LIMIT = 4,
  parameter logic [31:0] ERR_WORD   = 32'hBAD1BAD1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        merr
);

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DGRANT = 3'd1,
    IGRANT = 3'd2,
    DRESP  = 3'd3,
    IRESP  = 3'd4
  } state_t;

  state_t state;
  logic   dreq;
  logic   fair_force;

  assign dreq = dREN | dWEN;

`ifdef ARB_FAIRNESS_EN
  localparam int CNT_W = (FAIR_LIMIT < 1) ? 1 : $clog2(FAIR_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(FAIR_LIMIT);

  logic [CNT_W-1:0] fair_cnt;

  // Instruction side has waited through FAIR_LIMIT data grants: it goes next.
  assign fair_force = iREN && (fair_cnt == LIMIT);

  // Count data grants taken over a waiting instruction request; any
  // instruction grant or an idle cycle without iREN starts the count over.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fair_cnt <= '0;
    end else if (state == IDLE) begin
      if (!iREN || fair_force) begin
        fair_cnt <= '0;
      end else if (dreq) begin
        fair_cnt <= fair_cnt + 1'b1;
      end else begin
        fair_cnt <= '0;
      end
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // Arbitration FSM with registered wait/load/error outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      iwait <= 1'b1;
      dwait <= 1'b1;
      iload <= '0;
      dload <= '0;
      merr  <= 1'b0;
    end else begin
      merr <= 1'b0;
      case (state)
        IDLE: begin
          if (fair_force) begin
            state <= IGRANT;
          end else if (dreq) begin
            state <= DGRANT;
          end else if (iREN) begin
            state <= IGRANT;
          end
        end
        DGRANT: begin
          // A withdrawn request is abandoned silently, whatever the RAM says.
          if (!dreq) begin
            state <= IDLE;
          end else if (ramstate == RAM_ACCESS) begin
            dload <= ramload;
            dwait <= 1'b0;
            state <= DRESP;
          end else if (ramstate == RAM_ERROR) begin
            dload <= ERR_WORD;
            dwait <= 1'b0;
            merr  <= 1'b1;
            state <= DRESP;
          end
        end
        IGRANT: begin
          if (!iREN) begin
            state <= IDLE;
          end else if (ramstate == RAM_ACCESS) begin
            iload <= ramload;
            iwait <= 1'b0;
            state <= IRESP;
          end else if (ramstate == RAM_ERROR) begin
            iload <= ERR_WORD;
            iwait <= 1'b0;
            merr  <= 1'b1;
            state <= IRESP;
          end
        end
        DRESP: begin
          dwait <= 1'b1;
          state <= IDLE;
        end
        IRESP: begin
          iwait <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // RAM port is driven only in a grant state; address and data pass straight
  // through so the requester owns their stability. Reset forces IDLE
  // asynchronously, so the strobes drop as soon as nRST falls.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    case (state)
      DGRANT: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed sequences with a response scoreboard.
// Expected load values are queued when the RAM answer is driven and popped
// when the arbiter raises a response (wait low).
module tb_memory_arbiter;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic [1:0]  ramstate;
  logic        merr;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  int          checks = 0;
  int          errors = 0;
  int          merr_seen = 0;
  logic [31:0] dq[$];
  logic [31:0] iq[$];

  always #5 CLK = ~CLK;

  memory_arbiter #(
    .FAIR_LIMIT(4),
    .ERR_WORD  (32'hBAD1BAD1)
  ) dut (
    .CLK     (CLK),
    .nRST    (nRST),
    .iREN    (iREN),
    .iaddr   (iaddr),
    .iwait   (iwait),
    .iload   (iload),
    .dREN    (dREN),
    .dWEN    (dWEN),
    .daddr   (daddr),
    .dstore  (dstore),
    .dwait   (dwait),
    .dload   (dload),
    .ramREN  (ramREN),
    .ramWEN  (ramWEN),
    .ramaddr (ramaddr),
    .ramstore(ramstore),
    .ramload (ramload),
    .ramstate(ramstate),
    .merr    (merr)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Response scoreboard and error-pulse counter, sampled on the falling edge.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (dwait === 1'b0) begin
        check_eq("dresp_expected", 32'(dq.size() != 0), 32'd1);
        if (dq.size() != 0) check_eq("sb_dload", dload, dq.pop_front());
      end
      if (iwait === 1'b0) begin
        check_eq("iresp_expected", 32'(iq.size() != 0), 32'd1);
        if (iq.size() != 0) check_eq("sb_iload", iload, iq.pop_front());
      end
      if (merr === 1'b1) merr_seen++;
    end
  end

  initial begin
    int grants;
    int igrants;
    logic is_i;
    logic exp_i;

    nRST = 1'b0;
    iREN = 1'b0; iaddr = '0;
    dREN = 1'b0; dWEN = 1'b0; daddr = '0; dstore = '0;
    ramload = '0; ramstate = FREE;

    // Reset state
    #12;
    check_eq("rst_iwait", iwait, 1);
    check_eq("rst_dwait", dwait, 1);
    check_eq("rst_iload", iload, 0);
    check_eq("rst_dload", dload, 0);
    check_eq("rst_merr", merr, 0);
    check_eq("rst_ramREN", ramREN, 0);
    check_eq("rst_ramWEN", ramWEN, 0);
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Single instruction read, minimum latency
    iREN = 1'b1; iaddr = 32'h40;
    check_eq("t1_idle_ramREN", ramREN, 0);
    iq.push_back(32'h8C010004);
    tick();
    check_eq("t1_grant_ramREN", ramREN, 1);
    check_eq("t1_grant_ramaddr", ramaddr, 32'h40);
    check_eq("t1_grant_ramWEN", ramWEN, 0);
    check_eq("t1_grant_iwait", iwait, 1);
    ramstate = ACCESS; ramload = 32'h8C010004;
    tick();
    check_eq("t1_resp_iwait", iwait, 0);
    check_eq("t1_resp_iload", iload, 32'h8C010004);
    check_eq("t1_resp_ramREN", ramREN, 0);
    iREN = 1'b0; ramstate = FREE;
    tick();
    check_eq("t1_after_iwait", iwait, 1);
    check_eq("t1_after_iload", iload, 32'h8C010004);

    // Simultaneous instruction read and data write: data first
    iREN = 1'b1; iaddr = 32'h44;
    dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
    tick();
    check_eq("t2_dgrant_ramWEN", ramWEN, 1);
    check_eq("t2_dgrant_ramREN", ramREN, 0);
    check_eq("t2_dgrant_ramaddr", ramaddr, 32'h100);
    check_eq("t2_dgrant_ramstore", ramstore, 32'hDEADBEEF);
    check_eq("t2_dgrant_iwait", iwait, 1);
    dq.push_back(32'h11111111);
    ramstate = ACCESS; ramload = 32'h11111111;
    tick();
    check_eq("t2_dresp_dwait", dwait, 0);
    dWEN = 1'b0; ramstate = FREE;
    tick();
    check_eq("t2_idle_ramREN", ramREN, 0);
    check_eq("t2_idle_iwait", iwait, 1);
    tick();
    check_eq("t2_igrant_ramREN", ramREN, 1);
    check_eq("t2_igrant_ramaddr", ramaddr, 32'h44);
    iq.push_back(32'h22222222);
    ramstate = ACCESS; ramload = 32'h22222222;
    tick();
    check_eq("t2_iresp_iwait", iwait, 0);
    iREN = 1'b0; ramstate = FREE;
    tick();

    // Data read: RAM busy three cycles, then error
    dREN = 1'b1; daddr = 32'h200;
    tick();
    ramstate = BUSY;
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_busy_dwait", dwait, 1);
      check_eq("t3_busy_ramREN", ramREN, 1);
      tick();
    end
    ramstate = ERROR;
    dq.push_back(32'hBAD1BAD1);
    tick();
    check_eq("t3_err_dwait", dwait, 0);
    check_eq("t3_err_dload", dload, 32'hBAD1BAD1);
    check_eq("t3_err_merr", merr, 1);
    dREN = 1'b0; ramstate = FREE;
    tick();
    check_eq("t3_after_merr", merr, 0);
    check_eq("t3_after_dwait", dwait, 1);

    // Data request withdrawn during grant
    dREN = 1'b1; daddr = 32'h300;
    tick();
    check_eq("t4_grant_ramREN", ramREN, 1);
    dREN = 1'b0;
    tick();
    check_eq("t4_drop_dwait", dwait, 1);
    check_eq("t4_drop_dload", dload, 32'hBAD1BAD1);
    check_eq("t4_drop_ramREN", ramREN, 0);
    tick();
    check_eq("t4_later_dwait", dwait, 1);

    // Reset pulsed during an instruction grant
    iREN = 1'b1; iaddr = 32'h48;
    tick();
    check_eq("t5_grant_ramREN", ramREN, 1);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_eq("t5_rst_ramREN", ramREN, 0);
    check_eq("t5_rst_ramaddr", ramaddr, 0);
    check_eq("t5_rst_iwait", iwait, 1);
    check_eq("t5_rst_iload", iload, 0);
    iREN = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    check_eq("t5_after_ramREN", ramREN, 0);
    check_eq("t5_after_iwait", iwait, 1);

    // Continuous data and instruction reads, RAM always ready
    dREN = 1'b1; daddr = 32'h400;
    iREN = 1'b1; iaddr = 32'h80;
    ramstate = ACCESS;
    grants = 0;
    igrants = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (ramREN === 1'b1) begin
        is_i = (ramaddr == 32'h80);
`ifdef ARB_FAIRNESS_EN
        exp_i = ((grants % 5) == 4);
`else
        exp_i = 1'b0;
`endif
        check_eq("t6_grant_kind", 32'(is_i), 32'(exp_i));
        ramload = 32'hA0000000 + 32'(grants);
        if (exp_i) iq.push_back(ramload);
        else dq.push_back(ramload);
        if (is_i) igrants++;
        grants++;
      end
    end
    dREN = 1'b0; iREN = 1'b0; ramstate = FREE;
    tick();
    tick();
    check_eq("t6_grant_total", grants, 20);
`ifdef ARB_FAIRNESS_EN
    check_eq("t6_igrant_total", igrants, 4);
`else
    check_eq("t6_igrant_total", igrants, 0);
`endif

    // Scoreboard drained, exactly one error pulse overall
    check_eq("end_dq_empty", dq.size(), 0);
    check_eq("end_iq_empty", iq.size(), 0);
    check_eq("end_merr_pulses", merr_seen, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
